apb_uart_console_master: RTL and testbench

//  APB initiator that drives a 16550-style APB UART slave (8-bit regs at word offsets, paddr[4:2]=reg idx).

---
 rtl/apb_uart_console_master_if.sv | 13 +
 rtl/apb_uart_console_master.sv | 215 +++++++++++++++++++++
 tb/tb_apb_uart_console_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_console_master_if.sv
// apb_uart_console_master_if: APB bus between the console master and a 16550-style UART slave
interface apb_uart_console_master_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [31:0]               pwdata;
  logic [31:0]               prdata;
  logic                      pready;
  logic                      pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_uart_console_master.sv
// apb_uart_console_master: initialises a 16550 UART over APB, then polls LSR to move tx/rx bytes
module apb_uart_console_master #(
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter logic [APB_ADDR_WIDTH-1:0] UART_BASE      = '0,
  parameter logic [15:0]               DIVISOR        = 16'd27,
  parameter logic [7:0]                LCR_VAL        = 8'h03,
  parameter int                        POLL_GAP       = 4
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  apb_uart_console_master_if.master         m,
  input  logic                              tx_valid_i,
  input  logic [7:0]                        tx_data_i,
  output logic                              tx_ready_o,
  output logic                              rx_valid_o,
  output logic [7:0]                        rx_data_o,
  output logic                              rx_perr_o,
  input  logic                              rx_ready_i,
  output logic                              init_done_o,
  output logic                              err_o
);
  typedef enum logic [3:0] {
    ST_BOOT, ST_INIT_SETUP, ST_INIT_ACCESS, ST_POLL_SETUP, ST_POLL_ACCESS,
    ST_TX_SETUP, ST_TX_ACCESS, ST_RX_SETUP, ST_RX_ACCESS, ST_GAP, ST_IDLE
  } state_e;
  localparam logic [2:0] R_DAT = 3'd0, R_IER = 3'd1, R_FCR = 3'd2, R_LCR = 3'd3, R_LSR = 3'd5;
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  function automatic logic [2:0] init_reg(input logic [2:0] i);
    return (i == 3'd0 || i == 3'd3) ? R_LCR : (i == 3'd2 || i == 3'd5) ? R_IER : i == 3'd4 ? R_FCR : R_DAT;
  endfunction
  function automatic logic [7:0] init_dat(input logic [2:0] i);
    return i == 3'd0 ? (LCR_VAL | 8'h80) : i == 3'd1 ? DIVISOR[7:0] : i == 3'd2 ? DIVISOR[15:8] :
           i == 3'd3 ? LCR_VAL : i == 3'd4 ? 8'h07 : 8'h00;
  endfunction
  state_e                    state_q, state_d, l_state;
  logic [2:0]                init_idx_q, init_idx_d, l_reg;
  logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [7:0]                pwdata_q, pwdata_d, l_dat, lsr;
  logic                      tx_full_q, tx_full_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic [7:0]                rx_data_q, rx_data_d;
  logic                      lsr_rx_q, lsr_rx_d, lsr_perr_q, lsr_perr_d;
  logic                      init_done_q, init_done_d, err_q, err_d;
  logic                      done, launch, l_wr, go_poll;
  logic                      unused_prdata;
  assign unused_prdata = ^m.prdata[31:8];
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    gap_cnt_d   = gap_cnt_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    tx_full_d   = tx_full_q;
    tx_byte_d   = tx_byte_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    lsr_rx_d    = lsr_rx_q;
    lsr_perr_d  = lsr_perr_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    launch      = 1'b0;
    l_reg       = R_DAT;
    l_wr        = 1'b0;
    l_dat       = 8'h00;
    l_state     = ST_IDLE;
    go_poll     = 1'b0;
    done        = psel_q & penable_q & m.pready;
    lsr         = m.pslverr ? 8'h00 : m.prdata[7:0];
    if (tx_valid_i & ~tx_full_q) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data_i;
    end
    if (rx_valid_q & rx_ready_i) rx_valid_d = 1'b0;
    if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      if (m.pslverr) err_d = 1'b1;
    end
    case (state_q)
      ST_BOOT: begin
        launch  = 1'b1;
        l_reg   = init_reg(3'd0);
        l_wr    = 1'b1;
        l_dat   = init_dat(3'd0);
        l_state = ST_INIT_SETUP;
      end
      ST_INIT_SETUP, ST_POLL_SETUP, ST_TX_SETUP, ST_RX_SETUP: begin
        penable_d = 1'b1;
        state_d   = state_q == ST_INIT_SETUP ? ST_INIT_ACCESS : state_q == ST_POLL_SETUP ? ST_POLL_ACCESS :
                    state_q == ST_TX_SETUP ? ST_TX_ACCESS : ST_RX_ACCESS;
      end
      ST_INIT_ACCESS: if (done) begin
        if (init_idx_q == 3'd5) begin
          init_done_d = 1'b1;
          go_poll     = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          launch     = 1'b1;
          l_reg      = init_reg(init_idx_d);
          l_wr       = 1'b1;
          l_dat      = init_dat(init_idx_d);
          l_state    = ST_INIT_SETUP;
        end
      end
      ST_POLL_ACCESS: if (done) begin
        lsr_rx_d   = lsr[0];
        lsr_perr_d = lsr[2];
        if (lsr[5] & tx_full_q) begin
          launch  = 1'b1;
          l_wr    = 1'b1;
          l_dat   = tx_byte_q;
          l_state = ST_TX_SETUP;
        end else if (lsr[0] & ~rx_valid_q) begin
          launch  = 1'b1;
          l_state = ST_RX_SETUP;
        end else if (POLL_GAP == 0) begin
          go_poll = 1'b1;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GW'(POLL_GAP - 1);
        end
      end
      ST_TX_ACCESS: if (done) begin
        tx_full_d = 1'b0;
        if (lsr_rx_q & ~rx_valid_q) begin
          launch  = 1'b1;
          l_state = ST_RX_SETUP;
        end else go_poll = 1'b1;
      end
      ST_RX_ACCESS: if (done) begin
        if (!m.pslverr) begin
          rx_valid_d = 1'b1;
          rx_data_d  = m.prdata[7:0];
          rx_perr_d  = lsr_perr_q;
        end
        go_poll = 1'b1;
      end
      ST_GAP: if (gap_cnt_q == '0) go_poll = 1'b1; else gap_cnt_d = gap_cnt_q - 1'b1;
      default: go_poll = 1'b1;
    endcase
    // polling only makes sense when there is a byte to send or room for a byte to receive
    if (go_poll) begin
      if (tx_full_d | ~rx_valid_d) begin
        launch  = 1'b1;
        l_reg   = R_LSR;
        l_state = ST_POLL_SETUP;
      end else state_d = ST_IDLE;
    end
    if (launch) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = l_wr;
      paddr_d   = UART_BASE + APB_ADDR_WIDTH'({l_reg, 2'b00});
      pwdata_d  = l_dat;
      state_d   = l_state;
    end
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_BOOT;
      init_idx_q  <= '0;
      gap_cnt_q   <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_perr_q   <= 1'b0;
      lsr_rx_q    <= 1'b0;
      lsr_perr_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      tx_full_q   <= tx_full_d;
      tx_byte_q   <= tx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_perr_q   <= rx_perr_d;
      lsr_rx_q    <= lsr_rx_d;
      lsr_perr_q  <= lsr_perr_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end
  assign m.paddr     = paddr_q;
  assign m.psel      = psel_q;
  assign m.penable   = penable_q;
  assign m.pwrite    = pwrite_q;
  assign m.pwdata    = {24'h0, pwdata_q};
  assign tx_ready_o  = ~tx_full_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign rx_perr_o   = rx_perr_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_apb_uart_console_master.sv
// tb_apb_uart_console_master: scoreboard bench with an APB UART slave model and tx/rx stream agents
module tb_apb_uart_console_master;
  localparam int GAP = 4;
  typedef struct packed { logic [11:0] addr; logic wr; logic [7:0] data; } exp_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, rx_valid, rx_perr, init_done, err;
  logic [7:0] rx_data;
  logic [7:0] lsr_val = 8'h00, rbr_val = 8'h00;
  int stall_thr = 0, acc_cnt = 0, cyc = 0;
  logic err_thr = 1'b0, thr_wr;
  int checks = 0, errors = 0, last_acc = 0;
  exp_t exp_q[$];
  logic [8:0] rx_q[$];
  int done_cyc[$], lsr_cyc[$];
  apb_uart_console_master_if #(.APB_ADDR_WIDTH(12)) apb();
  apb_uart_console_master #(.APB_ADDR_WIDTH(12), .UART_BASE(12'h000), .DIVISOR(16'd27),
                            .LCR_VAL(8'h03), .POLL_GAP(GAP)) dut (
    .CLK(clk), .RSTN(rstn), .m(apb), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready), .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_perr_o(rx_perr),
    .rx_ready_i(rx_ready), .init_done_o(init_done), .err_o(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;
  always_comb begin
    thr_wr      = apb.psel && apb.penable && apb.pwrite && apb.paddr == 12'h000;
    apb.pready  = !(thr_wr && acc_cnt < stall_thr);
    apb.pslverr = thr_wr && apb.pready && err_thr;
    apb.prdata  = apb.paddr == 12'h014 ? {24'h0, lsr_val} : apb.paddr == 12'h000 ? {24'h0, rbr_val} : 32'h0;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_init();
    exp_q.push_back('{12'h00C, 1'b1, 8'h83});
    exp_q.push_back('{12'h000, 1'b1, 8'h1B});
    exp_q.push_back('{12'h004, 1'b1, 8'h00});
    exp_q.push_back('{12'h00C, 1'b1, 8'h03});
    exp_q.push_back('{12'h008, 1'b1, 8'h07});
    exp_q.push_back('{12'h004, 1'b1, 8'h00});
  endtask
  task automatic mon_apb();
    int ph = 0, acc_len = 0;
    logic [11:0] pa = '0;
    logic [31:0] pd = '0;
    logic pw = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ph = 0;
        acc_len = 0;
      end else if (apb.psel && !apb.penable) begin
        ph = 1; pa = apb.paddr; pd = apb.pwdata; pw = apb.pwrite;
      end else if (apb.psel && apb.penable) begin
        checks++;
        if (ph == 0 || apb.paddr !== pa || apb.pwdata !== pd || apb.pwrite !== pw) begin
          errors++;
          $display("FAIL apb_phase: got addr=%h data=%h wr=%b, setup addr=%h data=%h wr=%b ph=%0d",
                   apb.paddr, apb.pwdata, apb.pwrite, pa, pd, pw, ph);
        end
        acc_len++;
        if (apb.pready) begin
          if (apb.paddr == 12'h014 && !apb.pwrite) lsr_cyc.push_back(cyc);
          else begin
            done_cyc.push_back(cyc);
            last_acc = acc_len;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL apb_xfer: unexpected addr=%h wr=%b data=%h, expected none", apb.paddr, apb.pwrite, apb.pwdata);
            end else begin
              e = exp_q.pop_front();
              if (apb.paddr !== e.addr || apb.pwrite !== e.wr || (e.wr && apb.pwdata !== {24'h0, e.data})) begin
                errors++;
                $display("FAIL apb_xfer: got addr=%h wr=%b data=%h, expected addr=%h wr=%b data=%h",
                         apb.paddr, apb.pwrite, apb.pwdata, e.addr, e.wr, e.data);
              end
            end
          end
          ph = 0;
          acc_len = 0;
        end else ph = 2;
      end else ph = 0;
    end
  endtask
  task automatic mon_rx();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rstn && rx_valid && rx_ready) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_byte: unexpected perr=%b data=%h, expected none", rx_perr, rx_data);
        end else begin
          e = rx_q.pop_front();
          if ({rx_perr, rx_data} !== e) begin
            errors++;
            $display("FAIL rx_byte: got perr=%b data=%h, expected perr=%b data=%h", rx_perr, rx_data, e[8], e[7:0]);
          end
        end
      end
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    checks++;
    if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || apb.pwrite !== 1'b0 || apb.paddr !== 12'h0 ||
        apb.pwdata !== 32'h0 || rx_valid !== 1'b0 || rx_data !== 8'h0 || rx_perr !== 1'b0 ||
        init_done !== 1'b0 || err !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got psel=%b pen=%b pw=%b addr=%h wd=%h rxv=%b rxd=%h perr=%b done=%b err=%b txr=%b, expected all 0 with txr=1",
               tag, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, rx_valid, rx_data, rx_perr, init_done, err, tx_ready);
    end
  endtask
  task automatic offer_tx(input logic [7:0] b);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_offer_ready: got %b expected 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data = b;
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_capture: tx_ready got %b expected 0", tx_ready);
    end
  endtask
  task automatic wait_init();
    for (int i = 0; i < 200 && !init_done; i++) step();
    checks++;
    if (init_done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_done: got done=%b pending=%0d, expected done=1 pending=0", init_done, exp_q.size());
    end
  endtask
  task automatic test_reset();
    repeat (3) step();
    check_reset_outputs("reset_state");
  endtask
  task automatic test_init();
    done_cyc.delete();
    push_init();
    rstn = 1'b1;
    wait_init();
    for (int i = 1; i < 6 && done_cyc.size() >= 6; i++) begin
      checks++;
      if (done_cyc[i] - done_cyc[i-1] != 2) begin
        errors++;
        $display("FAIL init_spacing[%0d]: got %0d cycles expected 2", i, done_cyc[i] - done_cyc[i-1]);
      end
    end
    checks++;
    if (done_cyc.size() != 6) begin
      errors++;
      $display("FAIL init_count: got %0d writes expected 6", done_cyc.size());
    end
  endtask
  task automatic test_tx();
    int n = 0;
    lsr_val = 8'h60;
    done_cyc.delete();
    offer_tx(8'h41);
    exp_q.push_back('{12'h000, 1'b1, 8'h41});
    for (n = 0; n < 100 && exp_q.size() != 0; n++) begin
      if (tx_ready !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL tx_ready_hold: got %b expected 0", tx_ready);
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_write: pending=%0d tx_ready=%b, expected pending=0 tx_ready=1", exp_q.size(), tx_ready);
    end
    checks++;
    if (done_cyc.size() != 1 || lsr_cyc.size() == 0 || done_cyc[0] - lsr_cyc[$] != 2) begin
      errors++;
      $display("FAIL tx_after_lsr: THR write not 2 cycles after an LSR read (writes=%0d)", done_cyc.size());
    end
  endtask
  task automatic test_poll_gap();
    lsr_val = 8'h00;
    repeat (2) step();
    offer_tx(8'h55);
    lsr_cyc.delete();
    for (int i = 0; i < 200 && lsr_cyc.size() < 4; i++) step();
    checks++;
    if (lsr_cyc.size() < 4) begin
      errors++;
      $display("FAIL poll_timeout: got %0d polls expected 4", lsr_cyc.size());
    end else for (int i = 1; i < 4; i++) begin
      checks++;
      if (lsr_cyc[i] - lsr_cyc[i-1] != GAP + 2) begin
        errors++;
        $display("FAIL poll_gap[%0d]: got %0d cycles expected %0d", i, lsr_cyc[i] - lsr_cyc[i-1], GAP + 2);
      end
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL poll_tx_pending: tx_ready got %b expected 0", tx_ready);
    end
  endtask
  task automatic test_rx();
    done_cyc.delete();
    rbr_val = 8'h5A;
    exp_q.push_back('{12'h000, 1'b1, 8'h55});
    exp_q.push_back('{12'h000, 1'b0, 8'h00});
    rx_q.push_back({1'b1, 8'h5A});
    lsr_val = 8'h65;
    for (int i = 0; i < 100 && !rx_valid; i++) step();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_perr !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rx_load: got v=%b d=%h perr=%b pending=%0d, expected v=1 d=5a perr=1 pending=0",
               rx_valid, rx_data, rx_perr, exp_q.size());
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != 2) begin
      errors++;
      $display("FAIL rx_after_tx: RBR read not issued right after THR write (xfers=%0d)", done_cyc.size());
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_perr !== 1'b1 || apb.psel !== 1'b0) begin
        errors++;
        $display("FAIL rx_hold: got v=%b d=%h perr=%b psel=%b, expected v=1 d=5a perr=1 psel=0",
                 rx_valid, rx_data, rx_perr, apb.psel);
      end
    end
    lsr_val = 8'h60;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rx_consume: got v=%b pending=%0d, expected v=0 pending=0", rx_valid, rx_q.size());
    end
  endtask
  task automatic test_stall_err();
    stall_thr = 3;
    err_thr = 1'b1;
    offer_tx(8'h77);
    exp_q.push_back('{12'h000, 1'b1, 8'h77});
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || last_acc != 4) begin
      errors++;
      $display("FAIL thr_stall: got access cycles=%0d pending=%0d, expected 4 and 0", last_acc, exp_q.size());
    end
    checks++;
    if (err !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL thr_slverr: got err=%b tx_ready=%b, expected 1 and 1", err, tx_ready);
    end
    stall_thr = 0;
    err_thr = 1'b0;
    repeat (10) step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
  endtask
  task automatic test_reset_mid();
    stall_thr = 10;
    offer_tx(8'h88);
    for (int i = 0; i < 100 && !(apb.psel && apb.penable && apb.pwrite && apb.paddr == 12'h000); i++) step();
    checks++;
    if (!(apb.psel && apb.penable && apb.pwrite)) begin
      errors++;
      $display("FAIL mid_access: THR access not reached, psel=%b pen=%b", apb.psel, apb.penable);
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_access");
    exp_q.delete();
    stall_thr = 0;
    repeat (3) step();
    check_reset_outputs("reset_held");
    push_init();
    rstn = 1'b1;
    wait_init();
    repeat (5) step();
  endtask
  initial begin
    fork
      mon_apb();
      mon_rx();
    join_none
    test_reset();
    test_init();
    test_tx();
    test_poll_gap();
    test_rx();
    test_stall_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
